// File: rtl/pc_unit.sv
// Registered program counter with run/idle/fault control, stall, absolute call/return
// and a return-address stack with sticky overflow/underflow flags.
module pc_unit #(
    parameter int              PC_W        = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_ADDR  = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [PC_W-1:0] startadd_i,
    input  logic            stall_i,
    input  logic            branchf_i,
    input  logic            branchb_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [PC_W-1:0] pc_o,
    output logic            running_o,
    output logic            stack_empty_o,
    output logic            stack_full_o,
    output logic            overflow_o,
    output logic            underflow_o
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [AW-1:0]   top_idx;
    logic [PC_W-1:0] pc_inc;
    logic            act;
    logic            push;

    assign stack_empty_o = (count == '0);
    assign stack_full_o  = (count == CW'(STACK_DEPTH));
    assign top_idx       = AW'(count - CW'(1));
    assign pc_inc        = pc_o + PC_W'(1);
    // A non-stalled RUN cycle with no restart is the only time ret/call/branch act.
    assign act           = !start_i && (state == RUN) && !stall_i;
    assign push          = act && !ret_i && call_i && !stack_full_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_o        <= RESET_ADDR;
            state       <= IDLE;
            running_o   <= 1'b0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (start_i) begin
            pc_o        <= startadd_i;
            state       <= RUN;
            running_o   <= 1'b1;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (act) begin
            if (ret_i) begin
                if (!stack_empty_o) begin
                    pc_o  <= stack[top_idx];
                    count <= count - CW'(1);
                end else begin
                    underflow_o <= 1'b1;
                    state       <= FAULT;
                    running_o   <= 1'b0;
                end
            end else if (call_i) begin
                if (!stack_full_o) begin
                    pc_o  <= target_i;
                    count <= count + CW'(1);
                end else begin
                    overflow_o <= 1'b1;
                    state      <= FAULT;
                    running_o  <= 1'b0;
                end
            end else if (branchf_i) begin
                pc_o <= pc_inc + target_i;
            end else if (branchb_i) begin
                pc_o <= pc_inc - target_i;
            end else begin
                pc_o <= pc_inc;
            end
        end
    end

    // Entries survive pop and restart; only count is reset, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) stack[count[AW-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against a
// queue-based reference model.
module tb_pc_unit;
    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [7:0] startadd_i;
    logic       stall_i, branchf_i, branchb_i, call_i, ret_i;
    logic [7:0] target_i;
    logic [7:0] pc_o;
    logic       running_o, stack_empty_o, stack_full_o, overflow_o, underflow_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    localparam int M_IDLE = 0, M_RUN = 1, M_FAULT = 2;
    int       m_pc;
    int       m_mode;
    int       m_stk[$];
    bit       m_ov, m_un;

    pc_unit #(.PC_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .startadd_i(startadd_i),
        .stall_i(stall_i), .branchf_i(branchf_i), .branchb_i(branchb_i),
        .target_i(target_i), .call_i(call_i), .ret_i(ret_i), .pc_o(pc_o),
        .running_o(running_o), .stack_empty_o(stack_empty_o), .stack_full_o(stack_full_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0; m_mode = M_IDLE; m_stk.delete(); m_ov = 0; m_un = 0;
    endtask

    task automatic model_step(input bit st, input int sa, input bit stl, input bit bf,
                              input bit bb, input int tg, input bit cl, input bit rt);
        if (st) begin
            m_pc = sa; m_stk.delete(); m_ov = 0; m_un = 0; m_mode = M_RUN;
        end else if (m_mode == M_RUN && !stl) begin
            if (rt) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_un = 1; m_mode = M_FAULT; end
            end else if (cl) begin
                if (m_stk.size() < 4) begin m_stk.push_back((m_pc + 1) % 256); m_pc = tg; end
                else begin m_ov = 1; m_mode = M_FAULT; end
            end else if (bf) m_pc = (m_pc + 1 + tg) % 256;
            else if (bb) m_pc = (m_pc + 1 - tg + 256) % 256;
            else m_pc = (m_pc + 1) % 256;
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, return 1 time unit after the edge.
    task automatic drive(input bit st, input logic [7:0] sa, input bit stl, input bit bf,
                         input bit bb, input logic [7:0] tg, input bit cl, input bit rt);
        start_i = st; startadd_i = sa; stall_i = stl; branchf_i = bf; branchb_i = bb;
        target_i = tg; call_i = cl; ret_i = rt;
        @(posedge clk);
        model_step(st, int'(sa), stl, bf, bb, int'(tg), cl, rt);
        #1;
    endtask

    task automatic step_inc();
        drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic start_at(input logic [7:0] a);
        drive(1, a, 0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        start_at(8'h37);
        step_inc();
        #3 reset_i = 1'b1;
        model_reset();
        #1;
        checks++; if (pc_o !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc_o); end
        checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running_o); end
        checks++; if (stack_empty_o !== 1'b1 || stack_full_o !== 1'b0) begin
            errors++; $display("FAIL reset_stack: empty=%b full=%b want 1/0", stack_empty_o, stack_full_o); end
        checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ov=%b un=%b want 0/0", overflow_o, underflow_o); end
        #1 reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, i[0], i[1], 8'h11, i == 2, i == 3);
            checks++; if (pc_o !== 8'h00 || running_o !== 1'b0) begin
                errors++; $display("FAIL idle_hold[%0d]: pc=%h run=%b want 00/0", i, pc_o, running_o); end
        end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        start_at(8'hFC);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step_inc();
            checks++; if (pc_o !== exp_seq[i] || running_o !== 1'b1) begin
                errors++; $display("FAIL seq[%0d]: pc=%h run=%b want %h/1", i, pc_o, running_o, exp_seq[i]); end
        end
        start_at(8'hFC);
        step_inc();
        step_inc();
        for (int i = 0; i < 2; i++) begin
            drive(0, 8'h00, 1, 1, 0, 8'h07, 0, 0);
            checks++; if (pc_o !== 8'hFE) begin errors++; $display("FAIL stall[%0d]: got %h want FE", i, pc_o); end
        end
        step_inc();
        checks++; if (pc_o !== 8'hFF) begin errors++; $display("FAIL after_stall: got %h want FF", pc_o); end
    endtask

    task automatic test_branches();
        start_at(8'h10);
        drive(0, 8'h00, 0, 1, 0, 8'h05, 0, 0);
        checks++; if (pc_o !== 8'h16) begin errors++; $display("FAIL branch_fwd: got %h want 16", pc_o); end
        drive(0, 8'h00, 0, 0, 1, 8'h20, 0, 0);
        checks++; if (pc_o !== 8'hF7) begin errors++; $display("FAIL branch_bwd: got %h want F7", pc_o); end
        start_at(8'h10);
        drive(0, 8'h00, 0, 1, 1, 8'h05, 0, 0);
        checks++; if (pc_o !== 8'h16) begin errors++; $display("FAIL branch_both: got %h want 16", pc_o); end
    endtask

    task automatic test_call_ret();
        start_at(8'h20);
        drive(0, 8'h00, 0, 0, 0, 8'h80, 1, 0);
        checks++; if (pc_o !== 8'h80 || stack_empty_o !== 1'b0) begin
            errors++; $display("FAIL call1: pc=%h empty=%b want 80/0", pc_o, stack_empty_o); end
        drive(0, 8'h00, 0, 0, 0, 8'h90, 1, 0);
        checks++; if (pc_o !== 8'h90) begin errors++; $display("FAIL call2: got %h want 90", pc_o); end
        drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        checks++; if (pc_o !== 8'h81) begin errors++; $display("FAIL ret1: got %h want 81", pc_o); end
        drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        checks++; if (pc_o !== 8'h21 || stack_empty_o !== 1'b1) begin
            errors++; $display("FAIL ret2: pc=%h empty=%b want 21/1", pc_o, stack_empty_o); end
    endtask

    task automatic test_overflow();
        start_at(8'h00);
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 0, 0, 8'h10, 1, 0);
        checks++; if (stack_full_o !== 1'b1 || pc_o !== 8'h10) begin
            errors++; $display("FAIL fill: full=%b pc=%h want 1/10", stack_full_o, pc_o); end
        drive(0, 8'h00, 0, 0, 0, 8'h55, 1, 0);
        checks++; if (pc_o !== 8'h10 || overflow_o !== 1'b1 || running_o !== 1'b0) begin
            errors++; $display("FAIL overflow: pc=%h ov=%b run=%b want 10/1/0", pc_o, overflow_o, running_o); end
        drive(0, 8'h00, 0, 1, 0, 8'h03, 0, 0);
        drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        checks++; if (pc_o !== 8'h10 || overflow_o !== 1'b1 || stack_full_o !== 1'b1) begin
            errors++; $display("FAIL fault_frozen: pc=%h ov=%b full=%b want 10/1/1", pc_o, overflow_o, stack_full_o); end
        start_at(8'h40);
        checks++; if (pc_o !== 8'h40 || overflow_o !== 1'b0 || stack_empty_o !== 1'b1 || running_o !== 1'b1) begin
            errors++; $display("FAIL restart: pc=%h ov=%b empty=%b run=%b want 40/0/1/1",
                               pc_o, overflow_o, stack_empty_o, running_o); end
    endtask

    task automatic test_underflow_precedence();
        start_at(8'h30);
        drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        checks++; if (pc_o !== 8'h30 || underflow_o !== 1'b1 || running_o !== 1'b0) begin
            errors++; $display("FAIL underflow: pc=%h un=%b run=%b want 30/1/0", pc_o, underflow_o, running_o); end
        start_at(8'h50);
        checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL un_clear: got %b want 0", underflow_o); end
        drive(0, 8'h00, 0, 0, 0, 8'h60, 1, 0);
        drive(0, 8'h00, 0, 1, 0, 8'h99, 1, 1);
        checks++; if (pc_o !== 8'h51 || stack_empty_o !== 1'b1) begin
            errors++; $display("FAIL ret_over_call: pc=%h empty=%b want 51/1", pc_o, stack_empty_o); end
        drive(1, 8'h70, 1, 0, 0, 8'h00, 0, 0);
        checks++; if (pc_o !== 8'h70 || running_o !== 1'b1) begin
            errors++; $display("FAIL start_over_stall: pc=%h run=%b want 70/1", pc_o, running_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 24) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            checks++;
            if (pc_o !== 8'(m_pc) || running_o !== (m_mode == M_RUN) ||
                stack_empty_o !== (m_stk.size() == 0) || stack_full_o !== (m_stk.size() == 4) ||
                overflow_o !== m_ov || underflow_o !== m_un) begin
                errors++;
                $display("FAIL rand[%0d]: pc=%h run=%b e=%b f=%b ov=%b un=%b want pc=%h run=%b e=%b f=%b ov=%b un=%b",
                         i, pc_o, running_o, stack_empty_o, stack_full_o, overflow_o, underflow_o,
                         8'(m_pc), m_mode == M_RUN, m_stk.size() == 0, m_stk.size() == 4, m_ov, m_un);
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; start_i = 0; startadd_i = 0; stall_i = 0; branchf_i = 0;
        branchb_i = 0; target_i = 0; call_i = 0; ret_i = 0;
        model_reset();
        #12;
        test_reset();
        test_sequential();
        test_branches();
        test_call_ret();
        test_overflow();
        test_underflow_precedence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
